// File: rtl/arm_pipelined_execute_cond_stage.sv
// Decode->execute register fused with the ARM condition unit and NZCV flags.
// Optional build macro ARM_FLAG_WRITE_SPLIT_EN: independent N/Z and C/V flag-write enables.
module arm_pipelined_execute_cond_stage (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_Flush_Execute,
  input  logic       i_Reg_Write_Decode,
  input  logic       i_Mem_Write_Decode,
  input  logic       i_Mem_To_Reg_Decode,
  input  logic       i_ALU_Src_Decode,
  input  logic       i_Branch_Decode,
  input  logic       i_PC_Src_Decode,
  input  logic [1:0] i_ALU_Control_Decode,
  input  logic [1:0] i_Flag_Write_Decode,
  input  logic [3:0] i_Cond_Decode,
  input  logic [3:0] i_Write_Reg_Decode,
  input  logic [3:0] i_ALU_Flags,
  output logic       o_Reg_Write_Execute,
  output logic       o_Mem_Write_Execute,
  output logic       o_PC_Src_Execute,
  output logic       o_Mem_To_Reg_Execute,
  output logic       o_ALU_Src_Execute,
  output logic [1:0] o_ALU_Control_Execute,
  output logic [3:0] o_Write_Reg_Execute,
  output logic       o_Branch_Taken_Execute,
  output logic       o_Cond_Ex,
  output logic [3:0] o_Flags
);

  logic       reg_write_e, mem_write_e, mem_to_reg_e, alu_src_e, branch_e, pc_src_e;
  logic [1:0] alu_control_e, flag_write_e;
  logic [3:0] cond_e, write_reg_e, flags;
  logic       cond_ex, upd_nz, upd_cv;
  logic       n, z, c, v;

  // A flush or reset loads a bubble; all-zero Cond is EQ, which fails while Z=0.
  always_ff @(posedge i_CLK) begin
    if (i_RST || i_Flush_Execute) begin
      reg_write_e   <= 1'b0;
      mem_write_e   <= 1'b0;
      mem_to_reg_e  <= 1'b0;
      alu_src_e     <= 1'b0;
      branch_e      <= 1'b0;
      pc_src_e      <= 1'b0;
      alu_control_e <= 2'b00;
      flag_write_e  <= 2'b00;
      cond_e        <= 4'b0000;
      write_reg_e   <= 4'b0000;
    end else begin
      reg_write_e   <= i_Reg_Write_Decode;
      mem_write_e   <= i_Mem_Write_Decode;
      mem_to_reg_e  <= i_Mem_To_Reg_Decode;
      alu_src_e     <= i_ALU_Src_Decode;
      branch_e      <= i_Branch_Decode;
      pc_src_e      <= i_PC_Src_Decode;
      alu_control_e <= i_ALU_Control_Decode;
      flag_write_e  <= i_Flag_Write_Decode;
      cond_e        <= i_Cond_Decode;
      write_reg_e   <= i_Write_Reg_Decode;
    end
  end

  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = ~(n ^ v);
      4'b1011: cond_ex = n ^ v;
      4'b1100: cond_ex = ~z & ~(n ^ v);
      4'b1101: cond_ex = z | (n ^ v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

`ifdef ARM_FLAG_WRITE_SPLIT_EN
  assign upd_nz = flag_write_e[1] & cond_ex;
  assign upd_cv = flag_write_e[0] & cond_ex;
`else
  // Single enable: bit 1 writes all four flags, bit 0 is carried but ignored.
  logic unused_flag_write0;
  assign unused_flag_write0 = flag_write_e[0];
  assign upd_nz = flag_write_e[1] & cond_ex;
  assign upd_cv = upd_nz;
`endif

  // The executing instruction updates flags even when the incoming one is flushed.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      flags <= 4'b0000;
    end else begin
      if (upd_nz) flags[3:2] <= i_ALU_Flags[3:2];
      if (upd_cv) flags[1:0] <= i_ALU_Flags[1:0];
    end
  end

  assign o_Reg_Write_Execute    = reg_write_e & cond_ex;
  assign o_Mem_Write_Execute    = mem_write_e & cond_ex;
  assign o_PC_Src_Execute       = (pc_src_e | branch_e) & cond_ex;
  assign o_Branch_Taken_Execute = branch_e & cond_ex;
  assign o_Mem_To_Reg_Execute   = mem_to_reg_e;
  assign o_ALU_Src_Execute      = alu_src_e;
  assign o_ALU_Control_Execute  = alu_control_e;
  assign o_Write_Reg_Execute    = write_reg_e;
  assign o_Cond_Ex              = cond_ex;
  assign o_Flags                = flags;

endmodule

// File: tb/tb_arm_pipelined_execute_cond_stage.sv
// Bench for arm_pipelined_execute_cond_stage: directed table, condition sweep, random vs model.
module tb_arm_pipelined_execute_cond_stage;

  typedef struct packed {
    logic       rw, mw, m2r, asrc, br, pcs;
    logic [1:0] aluc, fw;
    logic [3:0] cond, wr;
  } dec_t;

  typedef struct {
    logic       rst, flush;
    dec_t       d;
    logic [3:0] alu;
    logic       cx, rw, mw, pcs, bt;
    logic [3:0] fl, wr;
  } vec_t;

  logic i_CLK = 1'b0;
  logic rst, flush;
  dec_t d;
  logic [3:0] alu;

  logic       o_Reg_Write_Execute, o_Mem_Write_Execute, o_PC_Src_Execute;
  logic       o_Mem_To_Reg_Execute, o_ALU_Src_Execute, o_Branch_Taken_Execute, o_Cond_Ex;
  logic [1:0] o_ALU_Control_Execute;
  logic [3:0] o_Write_Reg_Execute, o_Flags;

  int total = 0;
  int bad = 0;

  dec_t       ex_m;
  logic [3:0] fl_m;

  always #5 i_CLK = ~i_CLK;

  arm_pipelined_execute_cond_stage dut (
    .i_CLK(i_CLK), .i_RST(rst), .i_Flush_Execute(flush),
    .i_Reg_Write_Decode(d.rw), .i_Mem_Write_Decode(d.mw),
    .i_Mem_To_Reg_Decode(d.m2r), .i_ALU_Src_Decode(d.asrc),
    .i_Branch_Decode(d.br), .i_PC_Src_Decode(d.pcs),
    .i_ALU_Control_Decode(d.aluc), .i_Flag_Write_Decode(d.fw),
    .i_Cond_Decode(d.cond), .i_Write_Reg_Decode(d.wr), .i_ALU_Flags(alu),
    .o_Reg_Write_Execute(o_Reg_Write_Execute), .o_Mem_Write_Execute(o_Mem_Write_Execute),
    .o_PC_Src_Execute(o_PC_Src_Execute), .o_Mem_To_Reg_Execute(o_Mem_To_Reg_Execute),
    .o_ALU_Src_Execute(o_ALU_Src_Execute), .o_ALU_Control_Execute(o_ALU_Control_Execute),
    .o_Write_Reg_Execute(o_Write_Reg_Execute), .o_Branch_Taken_Execute(o_Branch_Taken_Execute),
    .o_Cond_Ex(o_Cond_Ex), .o_Flags(o_Flags)
  );

  // Condition rule from the architecture: pairs of codes share a base test, odd code inverts.
  function automatic logic cond_ref(input logic [3:0] cc, input logic [3:0] f);
    int nn, zz, cy, vv, b;
    nn = f[3]; zz = f[2]; cy = f[1]; vv = f[0];
    case (cc[3:1])
      3'd0: b = zz;
      3'd1: b = cy;
      3'd2: b = nn;
      3'd3: b = vv;
      3'd4: b = (cy == 1 && zz == 0) ? 1 : 0;
      3'd5: b = (nn == vv) ? 1 : 0;
      3'd6: b = (zz == 0 && nn == vv) ? 1 : 0;
      default: return (cc[0] == 1'b0);
    endcase
    return (b != 0) != (cc[0] == 1'b1);
  endfunction

  function automatic dec_t mkd(input logic rw_, mw_, br_, pcs_, input logic [1:0] fw_,
                               input logic [3:0] cond_, wr_);
    dec_t t;
    t = '0;
    t.rw = rw_; t.mw = mw_; t.br = br_; t.pcs = pcs_; t.fw = fw_; t.cond = cond_; t.wr = wr_;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Drive current inputs across one rising edge and advance the reference model.
  task automatic step();
    logic       cx;
    logic [3:0] nf;
    cx = cond_ref(ex_m.cond, fl_m);
    nf = fl_m;
    if (ex_m.fw[1] && cx) nf[3:2] = alu[3:2];
`ifdef ARM_FLAG_WRITE_SPLIT_EN
    if (ex_m.fw[0] && cx) nf[1:0] = alu[1:0];
`else
    if (ex_m.fw[1] && cx) nf[1:0] = alu[1:0];
`endif
    @(posedge i_CLK);
    #1;
    if (rst) begin
      fl_m = 4'b0000;
      ex_m = '0;
    end else begin
      fl_m = nf;
      ex_m = flush ? dec_t'('0) : d;
    end
  endtask

  task automatic chk_model(input string tag);
    logic cx;
    cx = cond_ref(ex_m.cond, fl_m);
    chk({tag, ".cond_ex"}, {3'b0, o_Cond_Ex}, {3'b0, cx});
    chk({tag, ".reg_write"}, {3'b0, o_Reg_Write_Execute}, {3'b0, ex_m.rw & cx});
    chk({tag, ".mem_write"}, {3'b0, o_Mem_Write_Execute}, {3'b0, ex_m.mw & cx});
    chk({tag, ".pc_src"}, {3'b0, o_PC_Src_Execute}, {3'b0, (ex_m.pcs | ex_m.br) & cx});
    chk({tag, ".br_taken"}, {3'b0, o_Branch_Taken_Execute}, {3'b0, ex_m.br & cx});
    chk({tag, ".misc"}, {o_Mem_To_Reg_Execute, o_ALU_Src_Execute, o_ALU_Control_Execute},
        {ex_m.m2r, ex_m.asrc, ex_m.aluc});
    chk({tag, ".write_reg"}, o_Write_Reg_Execute, ex_m.wr);
    chk({tag, ".flags"}, o_Flags, fl_m);
  endtask

  vec_t tbl[12];
  logic [3:0] split_res;

  initial begin
    rst = 1'b1; flush = 1'b0; d = '0; alu = 4'b0000;
    ex_m = '0; fl_m = 4'b0000;
`ifdef ARM_FLAG_WRITE_SPLIT_EN
    split_res = 4'b0011;
`else
    split_res = 4'b0000;
`endif
    //             rst   flush d                                             alu      cx    rw    mw    pcs   bt    flags      wr
    tbl[0]  = '{1'b1, 1'b0, dec_t'('1),                                  4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000,  4'd0};
    tbl[1]  = '{1'b1, 1'b0, dec_t'('1),                                  4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000,  4'd0};
    tbl[2]  = '{1'b0, 1'b0, mkd(1, 0, 0, 0, 2'b11, 4'b1110, 4'd1),       4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000,  4'd1};
    tbl[3]  = '{1'b0, 1'b0, mkd(0, 0, 1, 0, 2'b00, 4'b0000, 4'd0),       4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0100,  4'd0};
    tbl[4]  = '{1'b0, 1'b0, mkd(1, 1, 0, 0, 2'b00, 4'b0001, 4'd3),       4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100,  4'd3};
    tbl[5]  = '{1'b0, 1'b0, mkd(0, 0, 0, 0, 2'b11, 4'b1110, 4'd0),       4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100,  4'd0};
    tbl[6]  = '{1'b0, 1'b0, mkd(0, 0, 0, 0, 2'b10, 4'b1110, 4'd0),       4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111,  4'd0};
    tbl[7]  = '{1'b0, 1'b0, mkd(0, 0, 0, 0, 2'b00, 4'b1110, 4'd0),       4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, split_res, 4'd0};
    tbl[8]  = '{1'b0, 1'b0, mkd(1, 0, 0, 0, 2'b11, 4'b1110, 4'd7),       4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, split_res, 4'd7};
    tbl[9]  = '{1'b0, 1'b1, mkd(1, 0, 0, 0, 2'b00, 4'b1110, 4'd5),       4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010,  4'd0};
    tbl[10] = '{1'b0, 1'b0, mkd(1, 0, 0, 0, 2'b11, 4'b1110, 4'd9),       4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010,  4'd9};
    tbl[11] = '{1'b1, 1'b0, dec_t'('1),                                  4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000,  4'd0};

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; flush = tbl[i].flush; d = tbl[i].d; alu = tbl[i].alu;
      step();
      chk($sformatf("vec%0d.cond_ex", i), {3'b0, o_Cond_Ex}, {3'b0, tbl[i].cx});
      chk($sformatf("vec%0d.reg_write", i), {3'b0, o_Reg_Write_Execute}, {3'b0, tbl[i].rw});
      chk($sformatf("vec%0d.mem_write", i), {3'b0, o_Mem_Write_Execute}, {3'b0, tbl[i].mw});
      chk($sformatf("vec%0d.pc_src", i), {3'b0, o_PC_Src_Execute}, {3'b0, tbl[i].pcs});
      chk($sformatf("vec%0d.br_taken", i), {3'b0, o_Branch_Taken_Execute}, {3'b0, tbl[i].bt});
      chk($sformatf("vec%0d.flags", i), o_Flags, tbl[i].fl);
      chk($sformatf("vec%0d.write_reg", i), o_Write_Reg_Execute, tbl[i].wr);
      if (tbl[i].rst)
        chk($sformatf("vec%0d.ungated", i),
            {o_Mem_To_Reg_Execute, o_ALU_Src_Execute, o_ALU_Control_Execute}, 4'b0000);
    end

    // Condition sweep: load each flag value via an AL flag-setter, then walk all 16 codes.
    rst = 1'b0; flush = 1'b0;
    for (int f = 0; f < 16; f++) begin
      d = mkd(0, 0, 0, 0, 2'b11, 4'b1110, 4'd0); alu = 4'($urandom_range(0, 15));
      step();
      for (int cc = 0; cc < 16; cc++) begin
        d = mkd(0, 0, 1, 0, 2'b00, 4'(cc), 4'd0);
        alu = (cc == 0) ? 4'(f) : 4'($urandom_range(0, 15));
        step();
        chk($sformatf("sweep c%0d f%0d", cc, f), {3'b0, o_Cond_Ex}, {3'b0, cond_ref(4'(cc), 4'(f))});
        chk($sformatf("sweep br c%0d f%0d", cc, f), {3'b0, o_Branch_Taken_Execute},
            {3'b0, cond_ref(4'(cc), 4'(f))});
        if (cc == 15) chk($sformatf("sweep flags f%0d", f), o_Flags, 4'(f));
      end
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      d = dec_t'($urandom);
      alu = 4'($urandom_range(0, 15));
      flush = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 39) == 0);
      step();
      chk_model($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arm_pipelined_execute_cond_stage.md
# arm_pipelined_execute_cond_stage

Decode-to-execute pipeline register fused with the ARM condition unit. Captures the main decoder's control word each cycle, holds the architectural NZCV flags, evaluates the instruction's 4-bit condition field against them, and drives condition-gated write enables and the PC-source select into the execute, memory and writeback path. Sits directly downstream of the main and ALU decoders and upstream of the execute/memory register and the hazard unit.

## Interface
- No parameters; all widths are fixed by the ARM datapath.
- i_CLK  in  1  single clock; all state updates on rising edge
- i_RST  in  1  synchronous, active-high reset
- i_Flush_Execute  in  1  hazard unit request: load a bubble into the execute register
- i_Reg_Write_Decode, i_Mem_Write_Decode, i_Mem_To_Reg_Decode, i_ALU_Src_Decode, i_Branch_Decode, i_PC_Src_Decode  in  1 each  decoded control (i_PC_Src_Decode = write to R15)
- i_ALU_Control_Decode  in  2  ALU operation select
- i_Flag_Write_Decode  in  2  [1] updates N,Z; [0] updates C,V
- i_Cond_Decode  in  4  instruction bits [31:28]
- i_Write_Reg_Decode  in  4  destination register index
- i_ALU_Flags  in  4  {N,Z,C,V} produced by the execute-stage ALU this cycle
- o_Reg_Write_Execute, o_Mem_Write_Execute, o_PC_Src_Execute  out  1 each  condition-gated enables
- o_Mem_To_Reg_Execute, o_ALU_Src_Execute  out  1 each  registered, ungated
- o_ALU_Control_Execute  out  2; o_Write_Reg_Execute  out  4  registered, ungated
- o_Branch_Taken_Execute  out  1  Branch & CondEx (hazard unit flush source)
- o_Cond_Ex  out  1  condition passed for the instruction now in execute
- o_Flags  out  4  architectural {N,Z,C,V}

## Operation
- Execute register: on each edge loads all decode inputs; if i_RST or i_Flush_Execute, loads all-zero (bubble: every enable 0, Cond 0000, Flag_Write 00, Write_Reg 0).
- Condition check (combinational from registered Cond and o_Flags): EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 (NV) 0.
- Gating: Reg_Write, Mem_Write = registered value & CondEx. PC_Src = (PC_Src_reg | Branch_reg) & CondEx. Branch_Taken = Branch_reg & CondEx.
- Flags register: on edge, if Flag_Write_reg[1] & CondEx, N,Z <= i_ALU_Flags[3:2]; if Flag_Write_reg[0] & CondEx, C,V <= i_ALU_Flags[1:0]; otherwise hold.
- Flush affects only the incoming instruction; the instruction already in execute completes its flag update on the same edge.
- Reset wins over flush and over flag update.

## Timing
- Reset values: every output 0, o_Flags = 4'b0000, o_Cond_Ex = 0 (bubble Cond = EQ with Z=0).
- Decode→execute latency 1 cycle; o_Cond_Ex and gated enables valid combinationally in the same cycle the instruction occupies execute.
- Flags written by instruction N are seen by instruction N+1 in execute on the next cycle; no bypass required.
- Back-to-back flag-setting instructions: each edge applies only the executing instruction's update.
- Reset asserted mid-stream: next cycle all outputs 0 regardless of decode inputs.

## Configuration
- ARM_FLAG_WRITE_SPLIT_EN defined: two independent flag-write bits as described.
- Undefined: i_Flag_Write_Decode[1] is the single enable and updates all four flags; bit [0] is ignored.

## Test plan
- Reset: hold i_RST 2 cycles with all decode inputs 1 -> all outputs 0, o_Flags=0000.
- Flag set: ADDS (Flag_Write=11, Cond=1110), i_ALU_Flags=0100 -> next cycle o_Flags=0100; following BEQ (Cond=0000, Branch=1) -> o_Cond_Ex=1, o_PC_Src_Execute=1, o_Branch_Taken_Execute=1.
- Failed condition: flags 0100, STRNE (Cond=0001, Mem_Write=1) -> o_Mem_Write_Execute=0, o_Reg_Write_Execute=0, flags unchanged.
- Split write: flags 1111, instruction Flag_Write=10, i_ALU_Flags=0000 -> o_Flags=0011 with macro defined; 0000 without.
- Flush: i_Flush_Execute=1 while decode presents Reg_Write=1, Write_Reg=5 -> next cycle o_Reg_Write_Execute=0, o_Write_Reg_Execute=0; concurrently executing flag-setter still updates o_Flags.
- Condition sweep: all 16 Cond codes against all 16 flag values -> o_Cond_Ex matches the table; NV always 0, AL always 1.
